// File: rtl/vga_pkg.sv
// VGA 800x600@60 timing constants and the stage bundle type.
// Shared by the timing generator and every pixel-pipeline stage.
package vga_pkg;

    localparam int HOR_ACTIVE      = 800;
    localparam int HOR_TOTAL_TIME  = 1056;
    localparam int HOR_BLANK_START = 800;
    localparam int HOR_BLANK_TIME  = 256;
    localparam int HOR_SYNC_START  = 840;
    localparam int HOR_SYNC_TIME   = 128;

    localparam int VER_ACTIVE      = 600;
    localparam int VER_TOTAL_TIME  = 628;
    localparam int VER_BLANK_START = 600;
    localparam int VER_BLANK_TIME  = 28;
    localparam int VER_SYNC_START  = 601;
    localparam int VER_SYNC_TIME   = 4;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_if_t;

endpackage

// File: rtl/vga_delay.sv
// Delays a vga_if_t bundle by STAGES clock cycles.
// Ports: clk, rst (async, active-high), din bundle in, dout bundle out.
import vga_pkg::*;

module vga_delay #(
    parameter int STAGES = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  vga_if_t din,
    output vga_if_t dout
);

    vga_if_t pipe [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[STAGES-1];

endmodule

// File: rtl/draw_rect.sv
// Overlays a solid RECT_W x RECT_H rectangle onto the RGB stream, 2-clk latency.
// Ports: clk, rst, VGA timing + rgb in, xpos/ypos, same timing + rgb out.
import vga_pkg::*;

module draw_rect #(
    parameter int          RECT_W     = 48,
    parameter int          RECT_H     = 64,
    parameter logic [11:0] RECT_COLOR = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    vga_if_t     in_bus;
    vga_if_t     s1;
    vga_if_t     s2_in;
    vga_if_t     s2;
    logic [11:0] x_lat;
    logic [11:0] y_lat;
    logic        vblnk_d;
    logic        vblnk_rise;
    logic        hit;
    logic        hit_s1;
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic [12:0] x_end;
    logic [12:0] y_end;

    assign in_bus = '{hcount: hcount_in, hsync: hsync_in,
                      hblnk:  hblnk_in,  vcount: vcount_in,
                      vsync:  vsync_in,  vblnk: vblnk_in,
                      rgb:    rgb_in};

    assign vblnk_rise = vblnk_in & ~vblnk_d;

    // Position is only taken at vblank start so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d <= 1'b0;
            x_lat   <= '0;
            y_lat   <= '0;
        end else begin
            vblnk_d <= vblnk_in;
            if (vblnk_rise) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    // 13-bit sums: a left edge near 4095 must not wrap onto low hcount.
    assign h_ext = {2'b00, hcount_in};
    assign v_ext = {2'b00, vcount_in};
    assign x_end = {1'b0, x_lat} + 13'(RECT_W);
    assign y_end = {1'b0, y_lat} + 13'(RECT_H);

    assign hit = (h_ext >= {1'b0, x_lat}) && (h_ext < x_end) &&
                 (v_ext >= {1'b0, y_lat}) && (v_ext < y_end);

    vga_delay #(.STAGES(1)) u_s1 (
        .clk  (clk),
        .rst  (rst),
        .din  (in_bus),
        .dout (s1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_s1 <= 1'b0;
        end else begin
            hit_s1 <= hit;
        end
    end

    always_comb begin
        s2_in = s1;
        if (s1.hblnk || s1.vblnk) begin
            s2_in.rgb = 12'h000;
        end else if (hit_s1) begin
            s2_in.rgb = RECT_COLOR;
        end
    end

    vga_delay #(.STAGES(1)) u_s2 (
        .clk  (clk),
        .rst  (rst),
        .din  (s2_in),
        .dout (s2)
    );

    assign hcount_out = s2.hcount;
    assign hsync_out  = s2.hsync;
    assign hblnk_out  = s2.hblnk;
    assign vcount_out = s2.vcount;
    assign vsync_out  = s2.vsync;
    assign vblnk_out  = s2.vblnk;
    assign rgb_out    = s2.rgb;

endmodule
